// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: legality check, lane alignment, req/gnt/rvalid handshake, load extension.
// Stalls the pipeline while an access is in flight; pulses access_err on illegal or timed-out accesses.
module dmem_access_ctrl #(
  parameter int DM_ADDR_W   = 9,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [2:0]           func3,
  output logic                 stall,
  output logic [31:0]          rdata,
  output logic                 rdata_valid,
  output logic                 access_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DM_ADDR_W-3:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   mem_req_q, mem_we_q, rdata_valid_q, access_err_q, load_q;
  logic [DM_ADDR_W-3:0]   mem_addr_q;
  logic [3:0]             mem_be_q;
  logic [31:0]            mem_wdata_q, rdata_q;
  logic [1:0]             lane_q;
  logic [2:0]             f3_q;

  logic        access, legal, f3_ok, align_ok, range_ok;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ext_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign access = mem_read | mem_write;

  // A simultaneous read and write is treated as a read throughout.
  always_comb begin
    f3_ok = 1'b0;
    if (mem_read) f3_ok = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                          (func3 == 3'b100) || (func3 == 3'b101);
    else          f3_ok = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    align_ok = 1'b1;
    if (func3[1:0] == 2'b01) align_ok = (addr[0] == 1'b0);
    if (func3[1:0] == 2'b10) align_ok = (addr[1:0] == 2'b00);
    range_ok = (addr[31:DM_ADDR_W] == '0);
    legal    = f3_ok && align_ok && range_ok;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    if (!mem_read) begin
      case (func3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_d    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{wdata[15:0]}};
        end
        default: be_d = 4'b1111;
      endcase
    end
  end

  always_comb begin
    byte_sel = mem_rdata[8*lane_q +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_d = {24'b0, byte_sel};
      3'b101:  ext_d = {16'b0, half_sel};
      default: ext_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      access_err_q  <= 1'b0;
      load_q        <= 1'b0;
      lane_q        <= '0;
      f3_q          <= '0;
    end else begin
      rdata_valid_q <= 1'b0;
      access_err_q  <= 1'b0;
      case (state_q)
        IDLE: if (access) begin
          if (legal) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= ~mem_read;
            mem_addr_q  <= addr[DM_ADDR_W-1:2];
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            lane_q      <= addr[1:0];
            f3_q        <= func3;
            load_q      <= mem_read;
            cnt_q       <= '0;
            state_q     <= REQ;
          end else begin
            access_err_q <= 1'b1;
            rdata_q      <= '0;
            state_q      <= DONE;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= load_q ? WAIT_R : DONE;
          end else if (cnt_q == CNT_MAX) begin
            mem_req_q    <= 1'b0;
            access_err_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            rdata_q       <= ext_d;
            rdata_valid_q <= 1'b1;
            state_q       <= DONE;
          end else if (cnt_q == CNT_MAX) begin
            access_err_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall       = ((state_q == IDLE) && access) || (state_q == REQ) || (state_q == WAIT_R);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign access_err  = access_err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboarded directed bench for dmem_access_ctrl with a scripted gnt/rvalid memory responder.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [2:0]  func3;
  logic        stall, rdata_valid, access_err, mem_req, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;

  dmem_access_ctrl #(.DM_ADDR_W(9), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .func3(func3), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .access_err(access_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = memory request granted, 1 = load data, 2 = access error
    logic [31:0] a;
    logic [31:0] b;
    bit          chk_b;
  } ev_t;

  ev_t q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic exp_req(input logic we, input logic [6:0] ad, input logic [3:0] be, input logic [31:0] wd);
    ev_t e;
    e.kind = 0; e.a = 32'({we, ad, be}); e.b = wd; e.chk_b = we;
    q.push_back(e);
  endtask

  task automatic exp_rd(input logic [31:0] v);
    ev_t e;
    e.kind = 1; e.a = v; e.b = '0; e.chk_b = 1'b0;
    q.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.kind = 2; e.a = '0; e.b = '0; e.chk_b = 1'b0;
    q.push_back(e);
  endtask

  task automatic mon_ev(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    n_total++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_event kind=%0d a=0x%08h b=0x%08h, none expected", k, a, b);
    end else begin
      e = q.pop_front();
      if (e.kind == k && e.a === a && (!e.chk_b || e.b === b)) n_pass++;
      else $display("FAIL event: got kind=%0d a=0x%08h b=0x%08h expected kind=%0d a=0x%08h b=0x%08h",
                    k, a, b, e.kind, e.a, e.b);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req && mem_gnt) mon_ev(0, 32'({mem_we, mem_addr, mem_be}), mem_wdata);
      if (rdata_valid)        mon_ev(1, rdata, 32'h0);
      if (access_err)         mon_ev(2, 32'h0, 32'h0);
    end
  end

  // Present one EX/MEM access and play memory; gdly = granted request cycle index, rvdly = cycles from gnt to rvalid.
  task automatic do_access(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3, input int gdly, input int rvdly,
                           input logic [31:0] word, input int exp_stall);
    int  ncyc, req_cyc, gnt_at;
    bit  done;
    ncyc = 0; req_cyc = 0; gnt_at = -1; done = 0;
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; func3 = f3; mem_rdata = word;
    for (int c = 0; c < 60 && !done; c++) begin
      mem_gnt    = mem_req && (req_cyc == gdly);
      mem_rvalid = (gnt_at >= 0) && (c == gnt_at + rvdly);
      @(negedge clk);
      if (stall) ncyc++;
      else begin
        done = 1;
        chk({nm, "_req_low_done"}, 32'(mem_req), 32'h0);
      end
      if (mem_req) req_cyc++;
      if (mem_gnt) gnt_at = c;
      @(posedge clk); #1;
    end
    if (!done) chk({nm, "_done_timeout"}, 32'h0, 32'h1);
    chk({nm, "_stall_cycles"}, 32'(ncyc), 32'(exp_stall));
    mem_read = 0; mem_write = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; mem_read = 0; mem_write = 0; addr = 0; wdata = 0; func3 = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({stall, rdata, rdata_valid, access_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} != 0), 32'h0);
    @(posedge clk); #1;
    reset = 0;

    exp_req(1, 7'd4, 4'b1111, 32'hDEADBEEF);
    do_access("sw", 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 0, 32'h0, 2);

    exp_req(0, 7'd4, 4'b1111, 32'h0); exp_rd(32'hFFFFFF80);
    do_access("lb", 1, 0, 32'h13, 32'h0, 3'b000, 0, 2, 32'h80FF7F01, 4);
    exp_req(0, 7'd4, 4'b1111, 32'h0); exp_rd(32'h00000080);
    do_access("lbu", 1, 0, 32'h13, 32'h0, 3'b100, 0, 2, 32'h80FF7F01, 4);

    exp_req(1, 7'd1, 4'b1100, 32'hABCDABCD);
    do_access("sh", 0, 1, 32'h06, 32'h0000ABCD, 3'b001, 0, 0, 32'h0, 2);
    exp_req(0, 7'd1, 4'b1111, 32'h0); exp_rd(32'hFFFF8001);
    do_access("lh", 1, 0, 32'h06, 32'h0, 3'b001, 0, 1, 32'h80011234, 3);

    exp_req(1, 7'd7, 4'b0010, 32'h77777777);
    do_access("sb", 0, 1, 32'h1D, 32'h12345677, 3'b000, 0, 0, 32'h0, 2);
    exp_req(0, 7'd0, 4'b1111, 32'h0); exp_rd(32'h00001234);
    do_access("lhu", 1, 0, 32'h00, 32'h0, 3'b101, 0, 1, 32'hC3A51234, 3);
    exp_req(0, 7'd0, 4'b1111, 32'h0); exp_rd(32'hFFFFC3A5);
    do_access("lh_hi", 1, 0, 32'h02, 32'h0, 3'b001, 0, 1, 32'hC3A51234, 3);
    exp_req(0, 7'd127, 4'b1111, 32'h0); exp_rd(32'hCAFEF00D);
    do_access("lw_top", 1, 0, 32'h1FC, 32'h0, 3'b010, 0, 1, 32'hCAFEF00D, 3);

    exp_err();
    do_access("lw_misalign", 1, 0, 32'h02, 32'h0, 3'b010, 0, 1, 32'h0, 1);
    chk("illegal_rdata_zero", rdata, 32'h0);
    exp_err();
    do_access("sb_range", 0, 1, 32'h400, 32'h55, 3'b000, 0, 0, 32'h0, 1);
    exp_err();
    do_access("ld_f3_011", 1, 0, 32'h00, 32'h0, 3'b011, 0, 1, 32'h0, 1);

    exp_req(0, 7'd0, 4'b1111, 32'h0); exp_rd(32'h000000AB);
    do_access("rw_as_read", 1, 1, 32'h01, 32'hFFFFFFFF, 3'b100, 0, 1, 32'h0000AB00, 3);

    exp_err();
    do_access("gnt_timeout", 0, 1, 32'h20, 32'h11112222, 3'b010, 99, 0, 32'h0, 17);
    chk("timeout_rdata_held", rdata, 32'h000000AB);
    exp_req(1, 7'd9, 4'b1111, 32'h55AA55AA);
    do_access("gnt_last_cycle", 0, 1, 32'h24, 32'h55AA55AA, 3'b010, 15, 0, 32'h0, 17);
    exp_req(0, 7'd0, 4'b1111, 32'h0); exp_err();
    do_access("rvalid_timeout", 1, 0, 32'h00, 32'h0, 3'b010, 0, 99, 32'h12345678, 18);
    chk("rv_timeout_rdata_held", rdata, 32'h000000AB);

    // Reset while waiting for read data.
    exp_req(0, 7'd4, 4'b1111, 32'h0);
    mem_read = 1; addr = 32'h10; func3 = 3'b010; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0; mem_read = 0;
    @(negedge clk);
    chk("reset_mid_outputs", 32'({stall, rdata, rdata_valid, access_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} != 0), 32'h0);
    @(posedge clk); #1;
    mem_rvalid = 1;
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(negedge clk);
    chk("late_rvalid_ignored", 32'({rdata_valid, rdata, stall}), 32'h0);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- MEM-stage responder for the EX/MEM pipeline register. Consumes the register's MemRead, MemWrite, Alu_Result, RD_Two and func3 fields; drives a variable-latency word-wide data memory through a req/gnt/rvalid handshake.
- Returns load data, already extracted and extended, into the MEM/WB MemReadData field.
- Stalls the pipeline while an access is in flight and flags illegal accesses.

Parameters:
- DM_ADDR_W, 9: byte-address width of data memory. Word index is DM_ADDR_W-2 bits.
- TIMEOUT_CYC, 16: maximum cycles spent waiting for mem_gnt or mem_rvalid before the access is aborted. Must be at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  EX/MEM MemRead.
- mem_write  in  1  EX/MEM MemWrite.
- addr  in  32  EX/MEM Alu_Result, the byte address.
- wdata  in  32  EX/MEM RD_Two, the store data.
- func3  in  3  EX/MEM func3, the access size and signedness.
- stall  out  1  holds IF/ID/EX/MEM registers while 1.
- rdata  out  32  extended load data, feeds MEM/WB MemReadData.
- rdata_valid  out  1  one-cycle pulse when rdata holds a completed load.
- access_err  out  1  one-cycle pulse on an illegal or timed-out access.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  DM_ADDR_W-2  word index.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset values: state IDLE, timeout counter 0. All outputs 0: stall, rdata, rdata_valid, access_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset mid-access: the FSM returns to IDLE at the reset edge and mem_req drops the same edge. No err or valid pulse is produced.
- Access request: access = mem_read | mem_write. If both are set, treat it as a read.
- Legality:
  - Loads: func3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: func3 in {000 SB, 001 SH, 010 SW}.
  - Halfword accesses require addr[0]=0. Word accesses require addr[1:0]=0.
  - addr[31:DM_ADDR_W] must be 0.
  - Any violation makes the access illegal.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE, legal access: latch request fields into output registers, assert mem_req next cycle, go to REQ. stall is 1 combinationally in this cycle.
  - IDLE, illegal access: go to DONE with access_err=1 and rdata=0. No mem_req is issued. stall is 1 in this cycle.
  - REQ: mem_req=1, and mem_we/mem_addr/mem_be/mem_wdata stay stable until gnt.
    - On mem_gnt with a store: go to DONE.
    - On mem_gnt with a load: go to WAIT_R.
    - mem_req drops the cycle after gnt.
  - WAIT_R: on mem_rvalid, capture the extended data into rdata and go to DONE.
  - DONE: stall=0, and rdata_valid=1 for a completed load. The pipeline advances at the end of this cycle. Next state is IDLE.
    - rdata holds its value until the next load completes.
    - The new EX/MEM contents are first evaluated in IDLE on the following cycle, so back-to-back accesses cost a minimum of 3 cycles for stores and 4 cycles for loads with zero-wait memory.
- stall = (IDLE and access) or state in {REQ, WAIT_R}.
- Timeout counter:
  - Clears on entry to REQ or WAIT_R and increments each cycle in those states.
  - When it reaches TIMEOUT_CYC-1 without the expected gnt/rvalid, go to DONE with access_err=1, mem_req=0 and rdata unchanged.
  - gnt/rvalid arriving on the same cycle as the timeout wins; no error is raised.
- A late mem_rvalid while in IDLE/DONE is ignored.
- Store lanes, with lane = addr[1:0]:
  - SB: be = 1<<lane, wdata byte replicated to all 4 lanes.
  - SH: be = 0011 or 1100, halfword replicated to both halves.
  - SW: be = 1111.
- Loads:
  - mem_be = 1111.
  - Select a byte (lane addr[1:0]) or halfword (addr[1]) from mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_addr = addr[DM_ADDR_W-1:2].

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF, mem_gnt tied 1 -> mem_req for 1 cycle with mem_addr=4, be=1111, mem_wdata=0xDEADBEEF; stall high 2 cycles, then low in DONE; no rdata_valid.
- LB addr=0x13, mem_rdata=0x80FF7F01, gnt immediate, rvalid 2 cycles later -> rdata=0xFFFFFF80 with a rdata_valid pulse; the same access as LBU gives 0x00000080.
- SH addr=0x06, wdata=0x0000ABCD -> be=1100, mem_wdata=0xABCDABCD; LH from addr=0x06 with word 0x8001xxxx -> rdata=0xFFFF8001.
- LW addr=0x02, and SB addr=0x400 with DM_ADDR_W=9 -> access_err pulse, no mem_req, stall released after 1 cycle; func3=011 load -> access_err.
- mem_gnt held 0 with TIMEOUT_CYC=16 -> access_err exactly 16 cycles after entering REQ, then mem_req drops and stall releases; repeat with gnt arriving on the final cycle -> no error.
- Reset asserted in WAIT_R -> next cycle all outputs 0 and state IDLE; an rvalid arriving afterwards produces no rdata_valid pulse.
